// File: rtl/mrna_iso_pkg.sv
// Shared types and control-line map for the mRNA isolation sequencer.
// ctrl_o bit i follows the line list order below; 1 = closed/pressurized.
package mrna_iso_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD_CELLS = 4'd1,
    ST_LOAD_BEADS = 4'd2,
    ST_LYSIS      = 4'd3,
    ST_MIX        = 4'd4,
    ST_SEPARATE   = 4'd5,
    ST_WASTE      = 4'd6,
    ST_COLLECT    = 4'd7,
    ST_DONE       = 4'd8
  } state_e;

  localparam int CTRL_W      = 13;
  localparam int B_COLLECT   = 0;
  localparam int B_LYSIS_IN  = 1;
  localparam int B_LYSIS_OUT = 2;
  localparam int B_PUSH      = 3;
  localparam int B_PUMP1     = 4;
  localparam int B_PUMP2     = 5;
  localparam int B_PUMP3     = 6;
  localparam int B_SEP       = 7;
  localparam int B_SIEVE     = 8;
  localparam int B_WASTE     = 9;
  localparam int B_BEADS     = 10;
  localparam int B_CELLS_IN  = 11;
  localparam int B_CELLS_OUT = 12;

  localparam logic [CTRL_W-1:0] ALL_CLOSED = '1;

  // pump = {pump1, pump2, pump3}, only meaningful in MIX
  function automatic logic [CTRL_W-1:0] ctrl_for(state_e s, logic [2:0] pump);
    logic [CTRL_W-1:0] c;
    c = ALL_CLOSED;
    case (s)
      ST_LOAD_CELLS: begin c[B_CELLS_IN] = 1'b0; c[B_SIEVE] = 1'b0; c[B_CELLS_OUT] = 1'b0; end
      ST_LOAD_BEADS: begin c[B_BEADS] = 1'b0; c[B_SIEVE] = 1'b0; c[B_CELLS_OUT] = 1'b0; end
      ST_LYSIS:      begin c[B_LYSIS_IN] = 1'b0; c[B_LYSIS_OUT] = 1'b0; end
      ST_MIX:        begin c[B_PUMP1] = pump[2]; c[B_PUMP2] = pump[1]; c[B_PUMP3] = pump[0]; end
      ST_SEPARATE:   begin c[B_SEP] = 1'b0; c[B_PUSH] = 1'b0; end
      ST_WASTE:      begin c[B_WASTE] = 1'b0; c[B_PUSH] = 1'b0; end
      ST_COLLECT:    begin c[B_COLLECT] = 1'b0; c[B_PUSH] = 1'b0; end
      default:       c = ALL_CLOSED;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mrna_iso_pump_phase.sv
// Three-phase peristaltic pump pattern generator, PUMP_DIV cycles per phase.
// en is the *next-cycle* MIX flag so pump_nxt can be registered alongside state.
module mrna_iso_pump_phase #(
  parameter int PUMP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [2:0] pump_nxt,
  output logic       round_last
);
  import mrna_iso_pkg::*;

  localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PUMP_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    ph_q, ph_d;
  logic          act_q;

  // act_q low on the entry edge forces phase 0 (011) at MIX start
  always_comb begin
    div_d = '0;
    ph_d  = '0;
    if (en && act_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        ph_d  = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
      end else begin
        div_d = div_q + DW'(1);
        ph_d  = ph_q;
      end
    end
    case (ph_d)
      2'd0:    pump_nxt = 3'b011;
      2'd1:    pump_nxt = 3'b101;
      default: pump_nxt = 3'b110;
    endcase
  end

  assign round_last = act_q && (div_q == DIV_LAST) && (ph_q == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= 1'b0;
      div_q <= '0;
      ph_q  <= '0;
    end else begin
      act_q <= en;
      div_q <= div_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/mrna_iso_sequencer.sv
// mRNA isolation chip sequencer: timed valve steps plus a pump-driven MIX step.
// All outputs are registered from the next-state decode.
module mrna_iso_sequencer
  import mrna_iso_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int PUMP_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] t_step,
  input  logic [7:0]       n_mix,
  output logic             busy,
  output logic             done,
  output logic [3:0]       state_o,
  output logic [12:0]      ctrl_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, t_q, t_last;
  logic [7:0]       n_q, rnd_q;
  logic [2:0]       pump_nxt;
  logic             round_last, step_done, mix_done, timed;

  assign t_last    = (t_q == '0) ? '0 : t_q - CNT_W'(1);
  assign step_done = (cnt_q == t_last);
  assign mix_done  = round_last && (rnd_q == n_q - 8'd1);
  assign timed     = state_q inside {ST_LOAD_CELLS, ST_LOAD_BEADS, ST_LYSIS,
                                     ST_SEPARATE, ST_WASTE, ST_COLLECT};
  assign state_o   = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (start) state_d = ST_LOAD_CELLS;
      ST_LOAD_CELLS: if (step_done) state_d = ST_LOAD_BEADS;
      ST_LOAD_BEADS: if (step_done) state_d = ST_LYSIS;
      ST_LYSIS:      if (step_done) state_d = (n_q == 8'd0) ? ST_SEPARATE : ST_MIX;
      ST_MIX:        if (mix_done) state_d = ST_SEPARATE;
      ST_SEPARATE:   if (step_done) state_d = ST_WASTE;
      ST_WASTE:      if (step_done) state_d = ST_COLLECT;
      ST_COLLECT:    if (step_done) state_d = ST_DONE;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  mrna_iso_pump_phase #(.PUMP_DIV(PUMP_DIV)) u_pump (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state_d == ST_MIX),
    .pump_nxt   (pump_nxt),
    .round_last (round_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctrl_o  <= ALL_CLOSED;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt_q   <= '0;
      rnd_q   <= '0;
      t_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      ctrl_o  <= ctrl_for(state_d, pump_nxt);
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);
      if (state_q == ST_IDLE && state_d == ST_LOAD_CELLS) begin
        t_q <= t_step;
        n_q <= n_mix;
      end
      if (state_d != state_q) begin
        cnt_q <= '0;
        rnd_q <= '0;
      end else begin
        if (timed) cnt_q <= cnt_q + CNT_W'(1);
        if (state_q == ST_MIX && round_last) rnd_q <= rnd_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mrna_iso_sequencer.sv
// Bench: two instances (PUMP_DIV 4 and 2) share stimulus; expected per-cycle
// state/ctrl comes from a segment-duration model of the protocol.
module tb_mrna_iso_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort;
  logic [15:0] t_step;
  logic [7:0]  n_mix;
  logic        busy_a, done_a, busy_b, done_b;
  logic [3:0]  st_a, st_b;
  logic [12:0] ct_a, ct_b;

  int cmp  = 0;
  int errs = 0;

  // line indices in the documented order
  localparam int COLLECT = 0, LYS_IN = 1, LYS_OUT = 2, PUSH = 3, PUMP1 = 4;
  localparam int SEP = 7, SIEVE = 8, WASTE = 9, BEADS = 10, C_IN = 11, C_OUT = 12;

  mrna_iso_sequencer #(.CNT_W(16), .PUMP_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .t_step(t_step),
    .n_mix(n_mix), .busy(busy_a), .done(done_a), .state_o(st_a), .ctrl_o(ct_a));

  mrna_iso_sequencer #(.CNT_W(16), .PUMP_DIV(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .t_step(t_step),
    .n_mix(n_mix), .busy(busy_b), .done(done_b), .state_o(st_b), .ctrl_o(ct_b));

  function automatic logic [12:0] exp_ctrl(int st, int j, int pd);
    logic [12:0] c;
    c = '1;
    case (st)
      1: begin c[C_IN] = 0; c[SIEVE] = 0; c[C_OUT] = 0; end
      2: begin c[BEADS] = 0; c[SIEVE] = 0; c[C_OUT] = 0; end
      3: begin c[LYS_IN] = 0; c[LYS_OUT] = 0; end
      4: c[PUMP1 + (j / pd) % 3] = 0;
      5: begin c[SEP] = 0; c[PUSH] = 0; end
      6: begin c[WASTE] = 0; c[PUSH] = 0; end
      7: begin c[COLLECT] = 0; c[PUSH] = 0; end
      default: c = '1;
    endcase
    return c;
  endfunction

  function automatic int run_len(int pd, int t, int n);
    int te;
    te = (t == 0) ? 1 : t;
    return 6 * te + n * 3 * pd + 1;
  endfunction

  // {state, ctrl} expected at cycle i after the start edge
  function automatic logic [16:0] exp_at(int pd, int t, int n, int i);
    int dur[8];
    int te, j, found;
    logic [16:0] r;
    te = (t == 0) ? 1 : t;
    dur[0] = te; dur[1] = te; dur[2] = te; dur[3] = n * 3 * pd;
    dur[4] = te; dur[5] = te; dur[6] = te; dur[7] = 1;
    j = i; found = 0;
    r = {4'd0, 13'h1FFF};
    for (int k = 0; k < 8; k++) begin
      if (!found) begin
        if (j < dur[k]) begin
          r = {4'(k + 1), exp_ctrl(k + 1, j, pd)};
          found = 1;
        end else j -= dur[k];
      end
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    cmp++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_idle();
    chk("rst_state_a", 16'(st_a), 16'd0);   chk("rst_ctrl_a", 16'(ct_a), 16'h1FFF);
    chk("rst_busy_a", 16'(busy_a), 16'd0);  chk("rst_done_a", 16'(done_a), 16'd0);
    chk("rst_state_b", 16'(st_b), 16'd0);   chk("rst_ctrl_b", 16'(ct_b), 16'h1FFF);
    chk("rst_busy_b", 16'(busy_b), 16'd0);  chk("rst_done_b", 16'(done_b), 16'd0);
  endtask

  task automatic check_all(int i, int t, int n, int lim);
    logic [16:0] ea, eb;
    ea = (i < lim) ? exp_at(4, t, n, i) : {4'd0, 13'h1FFF};
    eb = (i < lim) ? exp_at(2, t, n, i) : {4'd0, 13'h1FFF};
    chk("state_a", 16'(st_a), 16'(ea[16:13]));
    chk("ctrl_a", 16'(ct_a), 16'(ea[12:0]));
    chk("busy_a", 16'(busy_a), 16'(ea[16:13] != 4'd0));
    chk("done_a", 16'(done_a), 16'(ea[16:13] == 4'd8));
    chk("state_b", 16'(st_b), 16'(eb[16:13]));
    chk("ctrl_b", 16'(ct_b), 16'(eb[12:0]));
    chk("busy_b", 16'(busy_b), 16'(eb[16:13] != 4'd0));
    chk("done_b", 16'(done_b), 16'(eb[16:13] == 4'd8));
  endtask

  // Called at a negedge; start is seen on the next posedge (cycle 0 sample follows)
  task automatic run(int t, int n, int abort_at, bit spur);
    int la, lb, lim, hi;
    la  = run_len(4, t, n);
    lb  = run_len(2, t, n);
    lim = (abort_at >= 0) ? abort_at + 1 : 1 << 30;
    hi  = (la > lb) ? la : lb;
    if (lim < hi) hi = lim;
    t_step = 16'(t); n_mix = 8'(n); start = 1'b1; abort = 1'b0;
    @(negedge clk);
    for (int i = 0; i < hi + 2; i++) begin
      check_all(i, t, n, lim);
      abort  = (i == abort_at);
      start  = spur && (i < lim) && (i < la) && (i < lb) && ($urandom_range(0, 3) == 0);
      t_step = 16'($urandom);
      n_mix  = 8'($urandom);
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b1; abort = 1'b0; t_step = 16'd3; n_mix = 8'd2;
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_idle();
    end
    rst_n = 1'b1;
    run(3, 2, -1, 1'b1);           // start held through reset, 43-cycle run
    run(5, 0, -1, 1'b1);           // MIX skipped
    run(0, 1, -1, 1'b0);           // zero step time behaves as one cycle
    run(3, 2, 10, 1'b1);           // abort on 2nd MIX cycle of the PUMP_DIV=4 unit
    for (int r = 0; r < 6; r++) begin
      int t, n, ab;
      t  = $urandom_range(0, 6);
      n  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, run_len(2, t, n) - 1) : -1;
      run(t, n, ab, 1'b1);
    end
    // reset mid-run: outputs idle immediately, no done, stays idle after release
    t_step = 16'd2; n_mix = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk_idle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
